// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU slice: opcode encodings and
// the bit positions of the NZCV status flags.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_RSV = 2'b11
    } alu_op_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage : alu_pkg

// File: rtl/alu_add_core.sv
// Combinational ripple-carry adder used by the ALU ADD path.
// Returns the WIDTH-bit sum, the carry out of the MSB and the signed overflow.
module alu_add_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign carry    = c[WIDTH];
    // Carry into the MSB differing from carry out of it is the same as
    // "operands share a sign and the result sign differs".
    assign overflow = c[WIDTH] ^ c[WIDTH-1];

endmodule : alu_add_core

// File: rtl/alu_add_logic.sv
// Registered ALU slice: ADD / AND / OR with NZCV flags and a valid bit,
// one cycle of latency, no backpressure.
module alu_add_logic
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags
);

    alu_op_e          op_sel;
    logic [WIDTH-1:0] add_sum;
    logic             add_carry;
    logic             add_overflow;
    logic [WIDTH-1:0] result;
    logic [3:0]       result_flags;

    assign op_sel = alu_op_e'(op);

    alu_add_core #(
        .WIDTH (WIDTH)
    ) u_add_core (
        .a        (in1),
        .b        (in2),
        .sum      (add_sum),
        .carry    (add_carry),
        .overflow (add_overflow)
    );

    // Select the operation result and derive the NZCV flags from it.
    always_comb begin
        result       = '0;
        result_flags = '0;
        unique case (op_sel)
            OP_ADD: begin
                result               = add_sum;
                result_flags[FLAG_C] = add_carry;
                result_flags[FLAG_V] = add_overflow;
            end
            OP_AND:  result = in1 & in2;
            OP_OR:   result = in1 | in2;
            default: result = '0;
        endcase
        result_flags[FLAG_N] = result[WIDTH-1];
        result_flags[FLAG_Z] = (result == '0);
    end

    // Output registers: valid follows in_valid, data/flags update only on valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            flags     <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out   <= result;
                flags <= result_flags;
            end
        end
    end

endmodule : alu_add_logic

// File: tb/tb_alu_add_logic.sv
// Self-checking bench for alu_add_logic: directed vector table, valid gating,
// reserved op, randomized ops against a reference model, async reset.
module tb_alu_add_logic;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        out_valid;
    logic [31:0] out;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        logic [3:0]  exp_flags;
    } vec_t;

    vec_t vecs[10];

    alu_add_logic #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out       (out),
        .flags     (flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: arithmetic on wide integers, signed overflow from range test.
    task automatic model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [3:0] f);
        longint unsigned s;
        longint          ss;
        logic            c;
        logic            v;
        c = 1'b0;
        v = 1'b0;
        case (mop)
            2'd0: begin
                s  = longint'(a) + longint'(b);
                r  = s[31:0];
                c  = (s > 64'h0000_0000_FFFF_FFFF);
                ss = longint'($signed(a)) + longint'($signed(b));
                v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            2'd1: r = a & b;
            2'd2: r = a | b;
            default: r = 32'd0;
        endcase
        f = {r[31], (r == 32'd0), c, v};
    endtask

    task automatic drive(input logic v, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = v;
        op       = o;
        in1      = a;
        in2      = b;
    endtask

    logic [31:0] exp_out;
    logic [3:0]  exp_flags;
    logic [31:0] m_out;
    logic [3:0]  m_flags;
    logic        rv;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    initial begin
        vecs[0] = '{"add_4_10",    2'd0, 32'd4,          32'd10, 32'd14,         4'b0000};
        vecs[1] = '{"add_29_4",    2'd0, 32'd29,         32'd4,  32'd33,         4'b0000};
        vecs[2] = '{"add_carry",   2'd0, 32'hFFFF_FFFF,  32'd1,  32'd0,          4'b0110};
        vecs[3] = '{"add_ovf",     2'd0, 32'h7FFF_FFFF,  32'd1,  32'h8000_0000,  4'b1001};
        vecs[4] = '{"and_4_10",    2'd1, 32'd4,          32'd10, 32'd0,          4'b0100};
        vecs[5] = '{"and_30_4",    2'd1, 32'd30,         32'd4,  32'd4,          4'b0000};
        vecs[6] = '{"and_ff_2",    2'd1, 32'hFFFF_FFFF,  32'd2,  32'd2,          4'b0000};
        vecs[7] = '{"or_4_10",     2'd2, 32'd4,          32'd10, 32'd14,         4'b0000};
        vecs[8] = '{"or_30_4",     2'd2, 32'd30,         32'd4,  32'd30,         4'b0000};
        vecs[9] = '{"or_ff_2",     2'd2, 32'hFFFF_FFFF,  32'd2,  32'hFFFF_FFFF,  4'b1000};

        // Reset held with active-looking inputs
        rst_n    = 1'b0;
        in_valid = 1'b1;
        op       = 2'd2;
        in1      = 32'hDEAD_BEEF;
        in2      = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out",       out,                32'd0);
        check("rst_flags",     {28'd0, flags},     32'd0);

        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_rst_out",       out,                32'd0);
        check("post_rst_flags",     {28'd0, flags},     32'd0);

        // Directed table, back-to-back
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            @(posedge clk);
            #1;
            check({vecs[i].name, "_valid"}, {31'd0, out_valid},    32'd1);
            check({vecs[i].name, "_out"},   out,                   vecs[i].exp_out);
            check({vecs[i].name, "_flags"}, {28'd0, flags},        {28'd0, vecs[i].exp_flags});
        end

        // Valid gating: two idle cycles with changing operands
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 2'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
            @(posedge clk);
            #1;
            check("idle_valid", {31'd0, out_valid}, 32'd0);
            check("idle_out",   out,                32'hFFFF_FFFF);
            check("idle_flags", {28'd0, flags},     32'b1000);
        end

        // Reserved op
        drive(1'b1, 2'd3, 32'd5, 32'd6);
        @(posedge clk);
        #1;
        check("rsv_valid", {31'd0, out_valid}, 32'd1);
        check("rsv_out",   out,                32'd0);
        check("rsv_flags", {28'd0, flags},     32'b0100);
        exp_out   = 32'd0;
        exp_flags = 4'b0100;

        // Randomized stream against the reference model
        for (int n = 0; n < 400; n++) begin
            rv  = ($urandom_range(0, 3) != 0);
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       ra = 32'hFFFF_FFFF;
                1:       ra = 32'h7FFF_FFFF;
                2:       ra = 32'h8000_0000;
                default: ra = $urandom;
            endcase
            rb = ($urandom_range(0, 3) == 0) ? 32'(-$signed(ra)) : $urandom;
            drive(rv, rop, ra, rb);
            if (rv) begin
                model(rop, ra, rb, m_out, m_flags);
                exp_out   = m_out;
                exp_flags = m_flags;
            end
            @(posedge clk);
            #1;
            check("rnd_valid", {31'd0, out_valid}, {31'd0, rv});
            check("rnd_out",   out,                exp_out);
            check("rnd_flags", {28'd0, flags},     {28'd0, exp_flags});
        end

        // Asynchronous reset between edges while a result is valid
        drive(1'b1, 2'd0, 32'd100, 32'hFFFF_FFF0);
        @(posedge clk);
        #1;
        check("pre_arst_valid", {31'd0, out_valid}, 32'd1);
        check("pre_arst_out",   out,                32'd84);
        check("pre_arst_flags", {28'd0, flags},     32'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out",   out,                32'd0);
        check("arst_flags", {28'd0, flags},     32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("after_arst_valid", {31'd0, out_valid}, 32'd0);
        check("after_arst_out",   out,                32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_alu_add_logic
